rv32c_fetch_aligner: RTL

- Parametrised fetch-side realignment buffer for mixed 16/32-bit RV32IC instruction streams.
- Issues aligned fetches of FETCH_WIDTH bits and queues the returned halfwords in a circular buffer.
- Emits one complete instruction per handshake: a compressed one zero-extended, or a 32-bit one reassembled across fetch-word boundaries.
- Sits between the I-memory port and the decode/decompress stage; it does not expand compressed instructions. It supports branch redirects to any halfword-aligned PC.

---
 rtl/rv32c_pkg.sv | 20 ++
 rtl/rv32c_fetch_aligner_if.sv | 29 ++
 rtl/hw_ring_buffer.sv | 79 +++++++
 rtl/rv32c_fetch_aligner.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rv32c_pkg.sv
// Shared types and constants for the RV32IC fetch aligner.
package rv32c_pkg;

  typedef logic [15:0] halfword_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  // Low two bits of a halfword that mark the first half of a 32-bit instruction.
  localparam logic [1:0] INST_32_MARK = 2'b11;

  function automatic logic is_inst32(input halfword_t hw);
    return hw[1:0] == INST_32_MARK;
  endfunction

endpackage

// File: rtl/rv32c_fetch_aligner_if.sv
// Fetch-port, redirect and instruction-output signals of the fetch aligner.
// The master side is the aligner; the slave side is memory plus consumer.
interface rv32c_fetch_aligner_if #(
  parameter int unsigned FETCH_WIDTH = 32
);
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic                   fetch_req;
  logic [31:0]            fetch_addr;
  logic                   fetch_gnt;
  logic                   fetch_valid;
  logic [FETCH_WIDTH-1:0] fetch_rdata;
  logic                   inst_valid;
  logic                   inst_ready;
  logic [31:0]            inst;
  logic [31:0]            inst_pc;
  logic                   is_compressed;

  modport master (
    input  redirect, redirect_pc, fetch_gnt, fetch_valid, fetch_rdata, inst_ready,
    output fetch_req, fetch_addr, inst_valid, inst, inst_pc, is_compressed
  );

  modport slave (
    output redirect, redirect_pc, fetch_gnt, fetch_valid, fetch_rdata, inst_ready,
    input  fetch_req, fetch_addr, inst_valid, inst, inst_pc, is_compressed
  );

endinterface

// File: rtl/hw_ring_buffer.sv
// Circular halfword queue: pushes up to HPF halfwords starting at an offset
// within the fetch word, pops 0/1/2 halfwords from the head.
module hw_ring_buffer
  import rv32c_pkg::*;
#(
  parameter int unsigned BUF_HW = 8,
  parameter int unsigned HPF    = 2,
  localparam int unsigned PtrW  = $clog2(BUF_HW),
  localparam int unsigned CntW  = $clog2(BUF_HW + 1),
  localparam int unsigned OffW  = (HPF > 1) ? $clog2(HPF) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [HPF-1:0][15:0]    push_data_i,
  input  logic [OffW-1:0]         push_start_i,
  input  logic [1:0]              pop_cnt_i,
  output halfword_t               head0_o,
  output halfword_t               head1_o,
  output logic [CntW-1:0]         count_o
);

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] push_num;
  halfword_t       mem_q [BUF_HW];

  // Pointer and occupancy update; a flush wins over any push or pop.
  always_comb begin
    push_num = '0;
    if (push_i) begin
      push_num = CntW'(HPF) - CntW'(push_start_i);
    end
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PtrW'(pop_cnt_i);
      tail_d  = tail_q + PtrW'(push_num);
      count_d = count_q + push_num - CntW'(pop_cnt_i);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write: halfwords below the start offset are not part of the stream.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < BUF_HW; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !flush_i) begin
      for (int unsigned i = 0; i < HPF; i++) begin
        if (i >= 32'(push_start_i)) begin
          mem_q[tail_q + PtrW'(i - 32'(push_start_i))] <= push_data_i[i];
        end
      end
    end
  end

  assign head0_o = mem_q[head_q];
  assign head1_o = mem_q[head_q + PtrW'(1)];
  assign count_o = count_q;

endmodule

// File: rtl/rv32c_fetch_aligner.sv
// Fetch-side realignment buffer for mixed 16/32-bit RV32IC streams: issues
// aligned fetches, queues halfwords and hands out one whole instruction per
// handshake. Compressed instructions are zero-extended, not expanded.
module rv32c_fetch_aligner
  import rv32c_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 32,
  parameter int unsigned BUF_HW      = 8,
  parameter logic [31:0] RESET_PC    = 32'h0000_0200
) (
  input logic                   CLK,
  input logic                   RST,
  rv32c_fetch_aligner_if.master bus
);

  localparam int unsigned Hpf        = FETCH_WIDTH / 16;
  localparam int unsigned FetchBytes = FETCH_WIDTH / 8;
  localparam int unsigned OffBits    = $clog2(FetchBytes);
  localparam int unsigned SkipW      = OffBits - 1;
  localparam int unsigned CntW       = $clog2(BUF_HW + 1);
  localparam logic [31:0] AlignMask  = ~(32'(FetchBytes) - 32'd1);

  fetch_state_t     state_q;
  logic             fetch_req_q;
  logic [31:0]      fetch_addr_q;
  logic [SkipW-1:0] skip_q;
  logic [31:0]      inst_pc_q;

  halfword_t        head0, head1;
  logic [CntW-1:0]  count;
  logic             head_comp;
  logic             inst_valid;
  logic             pop;
  logic [1:0]       pop_cnt;
  logic             push;
  logic             has_space;
  logic [Hpf-1:0][15:0] push_data;

  assign push_data = bus.fetch_rdata;
  // Only a response to a live request is queued; a redirect discards it.
  assign push      = (state_q == WAIT) && bus.fetch_valid && !bus.redirect;

  hw_ring_buffer #(
    .BUF_HW (BUF_HW),
    .HPF    (Hpf)
  ) u_buf (
    .CLK          (CLK),
    .RST          (RST),
    .flush_i      (bus.redirect),
    .push_i       (push),
    .push_data_i  (push_data),
    .push_start_i (skip_q),
    .pop_cnt_i    (pop_cnt),
    .head0_o      (head0),
    .head1_o      (head1),
    .count_o      (count)
  );

  // Head decode, output handshake and fetch space check.
  always_comb begin
    head_comp  = (count != '0) && !is_inst32(head0);
    inst_valid = head_comp || (count >= CntW'(2));
    pop        = inst_valid && bus.inst_ready && !bus.redirect;
    pop_cnt    = 2'd0;
    if (pop) begin
      pop_cnt = head_comp ? 2'd1 : 2'd2;
    end
    // Space is judged on the pre-pop count, so a granted fetch always fits.
    has_space  = (CntW'(BUF_HW) - count) >= CntW'(Hpf);
    bus.inst_valid    = inst_valid;
    bus.is_compressed = head_comp;
    bus.inst_pc       = inst_pc_q;
    if (count == '0) begin
      bus.inst = '0;
    end else if (head_comp) begin
      bus.inst = {16'h0000, head0};
    end else begin
      bus.inst = {head1, head0};
    end
  end

  assign bus.fetch_req  = fetch_req_q;
  assign bus.fetch_addr = fetch_addr_q;

  // Fetch FSM with PC tracking; redirect takes priority over everything.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= RESET_PC & AlignMask;
      skip_q       <= RESET_PC[OffBits-1:1];
      inst_pc_q    <= RESET_PC;
    end else if (bus.redirect) begin
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= bus.redirect_pc & AlignMask;
      skip_q       <= bus.redirect_pc[OffBits-1:1];
      inst_pc_q    <= bus.redirect_pc & 32'hFFFF_FFFE;
      unique case (state_q)
        IDLE: state_q <= IDLE;
        // A granted request still owes a response that must be swallowed.
        REQ:  state_q <= bus.fetch_gnt ? DROP : IDLE;
        WAIT: state_q <= bus.fetch_valid ? IDLE : DROP;
        // The outstanding response arriving now ends the drop; otherwise keep waiting.
        DROP: state_q <= bus.fetch_valid ? IDLE : DROP;
      endcase
    end else begin
      if (pop) begin
        inst_pc_q <= inst_pc_q + (head_comp ? 32'd2 : 32'd4);
      end
      unique case (state_q)
        IDLE: begin
          if (has_space) begin
            state_q     <= REQ;
            fetch_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.fetch_gnt) begin
            state_q     <= WAIT;
            fetch_req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.fetch_valid) begin
            state_q      <= IDLE;
            skip_q       <= '0;
            fetch_addr_q <= fetch_addr_q + 32'(FetchBytes);
          end
        end
        DROP: begin
          if (bus.fetch_valid) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
